mac_ktile_scheduler: RTL

- Sequences one matrix_multiplication_accumulation instance over a K-dimension reduction of T tiles: D_final = C_init + sum over t of A_t*B_t.
- Accepts a job config, streams A/B tiles into the MAC and feeds back each partial D as the next C.
- Returns one M x N 32-bit result per job.
- Works with combinational MACs (MODE 0/1, same-cycle valid) and sequential MACs (MODE 2, multi-cycle).

---
 rtl/mac_ktile_scheduler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mac_ktile_scheduler.sv
// Sequences one MAC over T K-dimension tiles: D = C_init + sum(A_t * B_t).
// Each partial D is fed back as the next C; one tile in flight at a time.
module mac_ktile_scheduler #(
   parameter int unsigned M          = 2,
   parameter int unsigned N          = 2,
   parameter int unsigned K          = 2,
   parameter int unsigned P          = 8,
   parameter int unsigned MAX_KTILES = 16,
   parameter int unsigned KT_W       = $clog2(MAX_KTILES + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cfg_valid_i,
   output logic                cfg_ready_o,
   input  logic [KT_W-1:0]     cfg_ktiles_i,
   input  logic                cfg_acc_init_i,
   input  logic [32*M*N-1:0]   c_init_i,
   input  logic [1:0]          cfg_halved_i,
   input  logic [3:0]          cfg_bitsize_a_i,
   input  logic [3:0]          cfg_bitsize_b_i,
   input  logic                tile_valid_i,
   output logic                tile_ready_o,
   input  logic [P*M*K-1:0]    tile_a_i,
   input  logic [P*K*N-1:0]    tile_b_i,
   output logic [P*M*K-1:0]    mac_a_o,
   output logic [P*K*N-1:0]    mac_b_o,
   output logic [32*M*N-1:0]   mac_c_o,
   output logic                mac_valid_o,
   input  logic                mac_ready_i,
   input  logic [32*M*N-1:0]   mac_d_i,
   input  logic                mac_valid_i,
   output logic                mac_ready_o,
   output logic [1:0]          mac_halved_o,
   output logic [3:0]          mac_bitsize_a_o,
   output logic [3:0]          mac_bitsize_b_o,
   output logic                res_valid_o,
   input  logic                res_ready_i,
   output logic [32*M*N-1:0]   res_d_o,
   output logic                busy_o,
   output logic [KT_W-1:0]     tile_cnt_o,
   output logic                err_o
);

   localparam int unsigned AW = P * M * K;
   localparam int unsigned BW = P * K * N;
   localparam int unsigned CW = 32 * M * N;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_OUTPUT
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   acc_q;
   logic [KT_W-1:0] cnt_q;
   logic [KT_W-1:0] kt_q;
   logic [1:0]      halved_q;
   logic [3:0]      bsa_q;
   logic [3:0]      bsb_q;
   logic            err_q;
   logic [AW-1:0]   a_q;
   logic [BW-1:0]   b_q;

   logic            cfg_fire;
   logic            issue_fire;
   logic            capture;
   logic            last_tile;
   logic [KT_W-1:0] cnt_inc;
   logic [KT_W-1:0] kt_clamped;

   assign cnt_inc    = cnt_q + KT_W'(1);
   assign last_tile  = (cnt_inc >= kt_q);
   assign kt_clamped = (cfg_ktiles_i > KT_W'(MAX_KTILES)) ? KT_W'(MAX_KTILES) : cfg_ktiles_i;

   always_comb begin
      state_d      = state_q;
      cfg_ready_o  = 1'b0;
      tile_ready_o = 1'b0;
      mac_valid_o  = 1'b0;
      mac_ready_o  = 1'b0;
      res_valid_o  = 1'b0;
      res_d_o      = '0;
      mac_a_o      = a_q;
      mac_b_o      = b_q;
      cfg_fire     = 1'b0;
      issue_fire   = 1'b0;
      capture      = 1'b0;
      case (state_q)
         S_IDLE: begin
            cfg_ready_o = 1'b1;
            cfg_fire    = cfg_valid_i;
            if (cfg_valid_i)
               state_d = (kt_clamped == '0) ? S_OUTPUT : S_ISSUE;
         end
         S_ISSUE: begin
            // Pass-through: a combinational MAC can answer in the issue cycle.
            mac_valid_o  = tile_valid_i;
            tile_ready_o = mac_ready_i;
            mac_a_o      = tile_a_i;
            mac_b_o      = tile_b_i;
            mac_ready_o  = 1'b1;
            issue_fire   = tile_valid_i && mac_ready_i;
            if (issue_fire) begin
               if (mac_valid_i) begin
                  capture = 1'b1;
                  state_d = last_tile ? S_OUTPUT : S_ISSUE;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            mac_ready_o = 1'b1;
            capture     = mac_valid_i;
            if (mac_valid_i)
               state_d = last_tile ? S_OUTPUT : S_ISSUE;
         end
         S_OUTPUT: begin
            res_valid_o = 1'b1;
            res_d_o     = acc_q;
            if (res_ready_i)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         kt_q     <= '0;
         halved_q <= '0;
         bsa_q    <= '0;
         bsb_q    <= '0;
         err_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         state_q <= state_d;
         if (cfg_fire) begin
            kt_q     <= kt_clamped;
            halved_q <= cfg_halved_i;
            bsa_q    <= cfg_bitsize_a_i;
            bsb_q    <= cfg_bitsize_b_i;
            acc_q    <= cfg_acc_init_i ? c_init_i : '0;
            cnt_q    <= '0;
         end
         if (issue_fire) begin
            a_q <= tile_a_i;
            b_q <= tile_b_i;
         end
         if (capture) begin
            acc_q <= mac_d_i;
            cnt_q <= cnt_inc;
         end
         if (mac_valid_i && (state_q == S_IDLE || state_q == S_OUTPUT))
            err_q <= 1'b1;
      end
   end

   assign mac_c_o         = acc_q;
   assign mac_halved_o    = halved_q;
   assign mac_bitsize_a_o = bsa_q;
   assign mac_bitsize_b_o = bsb_q;
   assign busy_o          = (state_q != S_IDLE);
   assign tile_cnt_o      = cnt_q;
   assign err_o           = err_q;

endmodule
